knop_event_arbiter: RTL
=======================

// Module: knop_event_arbiter
// PURPOSE
//  Front-end controller for the board push-buttons (knop) of the DLX toplevel.
//  - Synchronises and debounces each raw button.
//  - Detects presses and schedules simultaneous presses round-robin into a small event FIFO.
//  - Presents events to the processor's memory-mapped I/O port over a valid/ack handshake.
//  - Replaces ad-hoc polling of knop by software; sits between the board pins and the DLX I/O decoder.
// PARAMETERS
//  N_KNOP     4       number of buttons (2..8)
//  MAX_COUNT  100000  consecutive stable cycles required to accept a level (1 ms at 100 MHz)
//  FIFO_DEPTH 4       event FIFO entries, power of 2
// PORTS
//  clk_in        in   1         system clock, all logic rising-edge
//  reset         in   1         synchronous, active-high reset
//  knop          in   N_KNOP    raw asynchronous button levels, 1 = pressed
//  knop_stable   out  N_KNOP    debounced button levels
//  evt_valid     out  1         FIFO head holds an event
//  evt_id        out  3         button index of head event (upper bits 0 when N_KNOP<=4)
//  evt_ack       in   1         consumer pops head event
//  pending       out  clog2(FIFO_DEPTH)+1  events currently in FIFO
//  overflow      out  1         sticky: a press event was lost
//  clr_overflow  in   1         clears overflow
// BEHAVIOUR
//  Reset (sync, active-high, one clk_in edge):
//   - sync flops, debounce counters, knop_stable, pend bits, FIFO pointers and overflow = 0
//   - RR pointer = N_KNOP-1
//   - all outputs 0 on the cycle after the reset edge; any mid-operation state is discarded
//  Sync: 2-flop synchroniser per bit -> knop_s.
//  Debounce, per bit:
//   - if knop_s != knop_stable: cnt++
//   - if knop_s == knop_stable: cnt = 0
//   - on the edge where cnt == MAX_COUNT-1 and the bit still differs: knop_stable flips, cnt = 0
//   - raw-to-stable latency: 2 + MAX_COUNT cycles; any glitch shorter than that produces no change
//  Press detect:
//   - knop_stable 0->1 sets pend[i] on the next edge
//   - 1->0 (release) generates nothing
//  Lost events:
//   - a press on a bit whose pend[i] is already set is merged (lost) and sets overflow
//   - overflow set has priority over a simultaneous clr_overflow
//  Scheduler:
//   - each cycle, if any pend bit is set and the FIFO is not full, grant exactly one index
//   - search order starts at RR pointer+1, wrapping
//   - granted index is written to the FIFO, its pend bit is cleared, RR pointer = granted index
//   - a new press on the granted index in the same cycle re-sets pend (no loss)
//   - FIFO full: no grant; pend bits hold; the full-check ignores a same-cycle pop
//  FIFO handshake:
//   - evt_valid = !empty; evt_id = head entry, registered with no bubble
//   - pop on evt_valid & evt_ack; evt_ack while !evt_valid is ignored
//   - simultaneous push and pop keeps pending unchanged
//   - pointers wrap modulo FIFO_DEPTH; pending ranges 0..FIFO_DEPTH
//  Press-to-valid latency: stable rise at edge E -> pend at E+1 -> evt_valid high after E+2,
//   when the FIFO is not full and no other pend bit wins arbitration.
// TESTING (MAX_COUNT=4, N_KNOP=4, FIFO_DEPTH=4)
//  1. Single press: reset, then knop=4'b0001 held.
//     -> knop_stable=0001 after 6 cycles; evt_valid=1, evt_id=0, pending=1 two cycles later.
//     -> evt_ack for 1 cycle gives evt_valid=0, pending=0.
//  2. Bounce: knop[1] toggles every 2 cycles for 20 cycles, then 0.
//     -> knop_stable stays 0000; no event.
//  3. Simultaneous presses: knop 0000->1111.
//     -> four events in order 0,1,2,3; pending reaches 4; overflow=0.
//  4. Loss on a full FIFO: FIFO full without ack, then press/release/press knop[0] twice.
//     -> pend[0]=1 and overflow=1.
//     -> one evt_ack: event 0 is enqueued and pending returns to 4.
//     -> clr_overflow gives overflow=0.
//  5. Reset mid-operation: pending=3 with knop=0100 held, then a reset pulse.
//     -> next cycle: evt_valid=0, pending=0, knop_stable=0000, overflow=0.
//     -> a fresh event id=2 appears 2+4+2 cycles later.
//  6. Release only: knop held 1000 and stable, FIFO drained, then knop=0000.
//     -> knop_stable[3]=0 after 6 cycles; no event; pending stays 0.

Source files
------------

// File: rtl/knop_event_arbiter.sv
// Push-button front end: synchronise, debounce, detect presses, arbitrate them
// round-robin into a small event FIFO read over a valid/ack handshake.
module knop_event_arbiter #(
    parameter int N_KNOP     = 4,
    parameter int MAX_COUNT  = 100000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [N_KNOP-1:0]             knop,
    output logic [N_KNOP-1:0]             knop_stable,
    output logic                          evt_valid,
    output logic [2:0]                    evt_id,
    input  logic                          evt_ack,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam int CNT_W = $clog2(MAX_COUNT + 1);
    localparam int IDX_W = (N_KNOP > 1) ? $clog2(N_KNOP) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_COUNT - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    logic [N_KNOP-1:0] sync_p0, sync_p1, stable_prev;
    logic [CNT_W-1:0]  cnt [N_KNOP];
    logic [N_KNOP-1:0] pend, rise, loss, grant_oh;
    logic [IDX_W-1:0]  rr_ptr, grant_idx, cand;
    logic              grant_vld;
    logic [2:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              full, push, pop;

    // Stage p0/p1: two-flop synchroniser on the raw pins
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= knop;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: a level is accepted only after MAX_COUNT consecutive differing cycles
    always_ff @(posedge clk_in) begin
        if (reset) begin
            knop_stable <= '0;
            stable_prev <= '0;
            for (int i = 0; i < N_KNOP; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable_prev <= knop_stable;
            for (int i = 0; i < N_KNOP; i++) begin
                if (sync_p1[i] != knop_stable[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        knop_stable[i] <= sync_p1[i];
                        cnt[i]         <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign rise = knop_stable & ~stable_prev;
    assign full = (count == FIFO_FULL);

    // Round-robin search beginning just after the last granted index
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        cand      = '0;
        if ((|pend) && !full) begin
            for (int k = 1; k <= N_KNOP; k++) begin
                cand = IDX_W'((int'(rr_ptr) + k) % N_KNOP);
                if (!grant_vld && pend[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // A press only counts as lost when the granted bit is not the one being re-pressed
    assign loss = rise & pend & ~grant_oh;
    assign push = grant_vld;
    assign pop  = evt_valid & evt_ack;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            pend     <= '0;
            overflow <= 1'b0;
            rr_ptr   <= IDX_W'(N_KNOP - 1);
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            pend <= (pend & ~grant_oh) | rise;
            if (|loss) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
            if (grant_vld) begin
                rr_ptr <= grant_idx;
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage is data only and carries no reset; evt_id is masked while empty
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= 3'(grant_idx);
        end
    end

    assign evt_valid = (count != '0);
    assign evt_id    = evt_valid ? mem[rd_ptr] : 3'd0;
    assign pending   = count;

endmodule
